// File: rtl/note_pkg.sv
// Shared definitions for the note-sequence memory.
// Entry layout: note in [5:0], length in [10:6], bits [15:11] reserved.
// Also holds the frame sync byte and the loader state encoding.
package note_pkg;

    localparam int NOTE_LSB = 0;
    localparam int NOTE_W   = 6;
    localparam int LEN_LSB  = 6;
    localparam int LEN_W    = 5;

    localparam logic [7:0] SEQ_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte timeout counter.
// Counts enabled cycles since the last clear. It pulses expire on the
// TIMEOUT_CYCLES-th consecutive enabled, uncleared cycle.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   clr          : restart the count (a byte was transferred)
//   en           : count this cycle (a frame is in progress)
//   expire       : one-cycle pulse when the limit is reached
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;

    // cnt_reg holds the number of idle cycles already seen, so the limit
    // is hit while the count still reads TIMEOUT_CYCLES-1.
    assign expire = en && !clr && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || clr || !en || expire) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/note_seq_loader.sv
// Writer side of the note-sequence memory.
// Accepts a framed byte stream: SYNC (0xA5), COUNT N, N pairs (lo, hi)
// and, when NOTE_LOADER_CHECKSUM_EN is defined, a trailing XOR checksum.
// Each pair is written as one 16-bit entry {hi, lo} to the note RAM.
// A good frame publishes N-1 as the new sequence length; a bad or
// stalled frame pulses o_err and leaves the length untouched.
// Ports:
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_byte_valid/i_byte_data   : byte stream in, o_byte_ready handshake
//   o_ram_we/addr/wdata        : RAM write port, one pulse per entry
//   o_seq_len                  : last valid sequence index
//   o_busy                     : frame in progress (holds sequencer reset)
//   o_load_done / o_err        : commit / abort pulses
module note_seq_loader
    import note_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int RESET_LEN      = 15,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [15:0]       o_ram_wdata,
    output logic [ADDR_W-1:0] o_seq_len,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    loader_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [ADDR_W-1:0] last_reg, last_next;       // N-1 of the current frame
    logic [7:0]        lo_reg, lo_next;
    logic [7:0]        hi_reg, hi_next;
    logic [ADDR_W-1:0] seq_len_reg, seq_len_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
`ifdef NOTE_LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg, csum_next;
`endif

    logic transfer;
    logic expire;
    logic count_ok;

    assign o_byte_ready = (state_reg != ST_WRITE);
    assign transfer     = i_byte_valid && o_byte_ready;
    assign count_ok     = (i_byte_data != 8'd0) && ({1'b0, i_byte_data} <= 9'(DEPTH));

    assign o_ram_we    = (state_reg == ST_WRITE);
    assign o_ram_addr  = index_reg;
    assign o_ram_wdata = {hi_reg, lo_reg};
    assign o_seq_len   = seq_len_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_load_done = done_reg;
    assign o_err       = err_reg;

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clr    (transfer),
        .en     (state_reg != ST_IDLE),
        .expire (expire)
    );

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        last_next    = last_reg;
        lo_next      = lo_reg;
        hi_next      = hi_reg;
        seq_len_next = seq_len_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
`ifdef NOTE_LOADER_CHECKSUM_EN
        csum_next    = csum_reg;
`endif
        if (expire) begin
            // Only fires outside IDLE with no byte moving this cycle.
            err_next   = 1'b1;
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (transfer && (i_byte_data == SEQ_SYNC_BYTE)) begin
                        state_next = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (transfer) begin
                        if (count_ok) begin
                            last_next  = ADDR_W'(i_byte_data - 8'd1);
                            index_next = '0;
                            state_next = ST_LO;
`ifdef NOTE_LOADER_CHECKSUM_EN
                            csum_next  = i_byte_data;
`endif
                        end else begin
                            err_next   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_LO: begin
                    if (transfer) begin
                        lo_next    = i_byte_data;
                        state_next = ST_HI;
`ifdef NOTE_LOADER_CHECKSUM_EN
                        csum_next  = csum_reg ^ i_byte_data;
`endif
                    end
                end
                ST_HI: begin
                    if (transfer) begin
                        hi_next    = i_byte_data;
                        state_next = ST_WRITE;
`ifdef NOTE_LOADER_CHECKSUM_EN
                        csum_next  = csum_reg ^ i_byte_data;
`endif
                    end
                end
                ST_WRITE: begin
                    index_next = index_reg + 1'b1;
                    // Comparing against N-1 avoids an extra index bit for N == DEPTH.
                    if (index_reg == last_reg) begin
`ifdef NOTE_LOADER_CHECKSUM_EN
                        state_next   = ST_CSUM;
`else
                        seq_len_next = last_reg;
                        done_next    = 1'b1;
                        state_next   = ST_IDLE;
`endif
                    end else begin
                        state_next = ST_LO;
                    end
                end
`ifdef NOTE_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (transfer) begin
                        if (i_byte_data == csum_reg) begin
                            seq_len_next = last_reg;
                            done_next    = 1'b1;
                        end else begin
                            err_next     = 1'b1;
                        end
                        state_next = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            index_reg   <= '0;
            last_reg    <= '0;
            lo_reg      <= '0;
            hi_reg      <= '0;
            seq_len_reg <= ADDR_W'(RESET_LEN);
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
`ifdef NOTE_LOADER_CHECKSUM_EN
            csum_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            last_reg    <= last_next;
            lo_reg      <= lo_next;
            hi_reg      <= hi_next;
            seq_len_reg <= seq_len_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
`ifdef NOTE_LOADER_CHECKSUM_EN
            csum_reg    <= csum_next;
`endif
        end
    end

endmodule

// File: doc/note_seq_loader.md
Name: note_seq_loader

Overview:
- Writer side of the note-sequence memory.
- Receives a framed byte stream (e.g. from a UART receiver) and assembles 16-bit note entries: note in [5:0], length in [10:5+1]=[10:6].
- Writes each entry into the dual-port note RAM that the note sequencer reads.
- Publishes the new sequence length and holds the sequencer in reset while a load is in progress.

Parameters:
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W entries (32).
- RESET_LEN, 15, value of o_seq_len after reset (last valid index).
- TIMEOUT_CYCLES, 1000000, maximum i_clk cycles allowed between accepted bytes inside a frame.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_byte_valid  in  1  input byte valid
- i_byte_data  in  8  input byte
- o_byte_ready  out  1  loader can accept a byte
- o_ram_we  out  1  RAM write enable, one-cycle pulse per entry
- o_ram_addr  out  ADDR_W  RAM write address
- o_ram_wdata  out  16  RAM write data = {hi, lo}
- o_seq_len  out  ADDR_W  last valid sequence index, for the sequencer wrap point
- o_busy  out  1  frame in progress; drives the sequencer's reset
- o_load_done  out  1  one-cycle pulse when a frame commits
- o_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: i_rst is synchronous, active-high, on i_clk. It has priority in every state, including mid-frame.
  - State goes to IDLE.
  - o_ram_we, o_busy, o_load_done, o_err = 0.
  - o_ram_addr, o_ram_wdata = 0.
  - o_seq_len = RESET_LEN.
  - Entry index, count, checksum and timeout counter are cleared.
- Handshake: a byte transfers when i_byte_valid & o_byte_ready. o_byte_ready = 1 in every state except WRITE.
- Frame format: SYNC (0xA5), COUNT N, then N pairs (lo, hi), then an optional checksum byte.
- State machine:
  - IDLE: wait for a transfer of 0xA5 → COUNT. Any other byte is accepted and discarded.
  - COUNT: if N == 0 or N > DEPTH → o_err pulse, go to IDLE. Otherwise latch N, clear the index → LO.
  - LO: latch lo → HI.
  - HI: latch hi → WRITE.
  - WRITE (1 cycle): o_ram_we = 1, o_ram_addr = index, o_ram_wdata = {hi, lo}. Then index+1.
    - If index+1 == N → commit (or → CSUM when the feature is enabled).
    - Otherwise → LO.
  - Commit (registered, same cycle as leaving WRITE/CSUM): o_seq_len <= N-1 (truncated to ADDR_W), o_load_done pulse, → IDLE.
- o_busy = 1 in every state except IDLE. It asserts the cycle after SYNC is accepted and deasserts in the cycle the commit or abort pulse is seen.
- Latency: RAM write occurs 1 cycle after the hi byte transfers. o_load_done occurs 1 cycle after the last write.
- Timeout: the counter runs in any state except IDLE and clears on every transfer. When it reaches TIMEOUT_CYCLES → o_err pulse, → IDLE.
- Aborts (timeout, bad COUNT, bad checksum):
  - o_seq_len is unchanged.
  - Entries already written stay in the RAM; the committed length is not extended.
- Data bits [15:11] are written as received; they are reserved and ignored by the sequencer.
- N == DEPTH (32): the last write goes to address DEPTH-1 and o_seq_len = DEPTH-1. No address wrap occurs within a frame.
- A SYNC byte received mid-frame is treated as data, not as resync.
- o_load_done and o_err are never asserted in the same cycle.

Optional Feature:
- Macro: NOTE_LOADER_CHECKSUM_EN.
- When defined:
  - A CSUM state follows the last WRITE.
  - The expected byte is the XOR of COUNT and all 2N data bytes.
  - Match → commit.
  - Mismatch → o_err, o_seq_len unchanged.
  - o_ready stays 1 in CSUM.
- When undefined: there is no CSUM state and commit follows the last WRITE directly. A trailing byte is treated as frame noise in IDLE.

Decomposition:
- Shared package note_pkg holds:
  - NOTE_LSB = 0 / NOTE_W = 6.
  - LEN_LSB = 6 / LEN_W = 5.
  - SEQ_SYNC_BYTE = 8'hA5.
  - Loader state encoding constants.
- One sub-module, byte_timeout: a counter with clear and enable inputs and an expire pulse output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then frame A5 03 (01 00)(42 00)(83 01) → writes addr0 = 0x0001, addr1 = 0x0042, addr2 = 0x0183, each a 1-cycle we. Then o_seq_len = 2, o_load_done pulse once, o_busy high from the cycle after A5 until done.
- Garbage 00 FF 12 then A5 01 (05 00) → garbage bytes are discarded with no writes; addr0 = 0x0005; o_seq_len = 0.
- A5 00 → o_err pulse, no writes, o_seq_len stays 15. A5 21 (33 > DEPTH) → o_err, same result.
- A5 20 followed by 32 pairs → last write at addr 31, o_seq_len = 31.
- TIMEOUT_CYCLES = 50: A5 02 (10 00) then idle 50 cycles → addr0 is written, o_err pulses, o_seq_len unchanged, o_busy = 0. i_rst asserted during HI instead → idle state, no write, o_seq_len = 15.
- With NOTE_LOADER_CHECKSUM_EN: A5 01 (07 00) checksum 06 → done, o_seq_len = 0. Checksum 00 → o_err, o_seq_len unchanged.
